// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the RAM port B arbiter.
//   WIDTH_DEF   - default data/address width
//   IO_ADDR_DEF - default address of the memory-mapped button register
//   owner_t     - which requester owns an access
//   key_t       - button code returned by a read of the button register
//   stage_t     - response pipeline entry
package mem_arb_pkg;

    localparam int WIDTH_DEF = 16;
    localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;

    typedef enum logic {
        OWN_CPU,
        OWN_AUX
    } owner_t;

    typedef enum logic [1:0] {
        KEY_NONE  = 2'd0,
        KEY_START = 2'd1,
        KEY_LEFT  = 2'd2,
        KEY_RIGHT = 2'd3
    } key_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   is_read;
        logic   is_io;
    } stage_t;

    // Priority encode pressed buttons (active-high here): start, then left, then right.
    function automatic key_t key_encode(input logic start_p, input logic left_p, input logic right_p);
        return start_p ? KEY_START : left_p ? KEY_LEFT : right_p ? KEY_RIGHT : KEY_NONE;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter for the issue stage.
//   clk, reset         - clock, synchronous active-high reset
//   cpu_req, aux_req   - requests seen this cycle
//   gnt                - one-hot combinational grant, bit 0 = CPU, bit 1 = AUX
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_req,
    input  logic       aux_req,
    output logic [1:0] gnt
);

    owner_t last_owner;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt = (cpu_req && aux_req) ? ((last_owner == OWN_AUX) ? 2'b01 : 2'b10)
                                   : {aux_req, cpu_req};
    end

    always_ff @(posedge clk) begin
        if (reset)
            last_owner <= OWN_AUX;
        else if (|gnt)
            last_owner <= gnt[1] ? OWN_AUX : OWN_CPU;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares RAM port B between the CPU load/store unit and an
// auxiliary master with round-robin arbitration and a fixed two-cycle read latency.
//   clk, reset                         - clock, synchronous active-high reset
//   cpu_req/we/addr/wdata              - CPU request fields
//   cpu_gnt, cpu_rvalid, cpu_rdata     - CPU grant pulse and read response
//   aux_*                              - same set for the auxiliary master
//   mem_we_b, mem_addr_b, mem_data_b   - registered RAM port B controls
//   mem_q_b                            - RAM port B registered read data
//   start_n, left_n, right_n           - raw active-low buttons
// Optional macro IO_KEYS_EN: reads of IO_ADDR return a synchronized button code
// and writes to IO_ADDR are granted but never reach the RAM.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter logic [WIDTH-1:0] IO_ADDR = WIDTH'(IO_ADDR_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output logic [WIDTH-1:0] cpu_rdata,
    input  logic             aux_req,
    input  logic             aux_we,
    input  logic [WIDTH-1:0] aux_addr,
    input  logic [WIDTH-1:0] aux_wdata,
    output logic             aux_gnt,
    output logic             aux_rvalid,
    output logic [WIDTH-1:0] aux_rdata,
    output logic             mem_we_b,
    output logic [WIDTH-1:0] mem_addr_b,
    output logic [WIDTH-1:0] mem_data_b,
    input  logic [WIDTH-1:0] mem_q_b,
    input  logic             start_n,
    input  logic             left_n,
    input  logic             right_n
);

    logic [1:0]       gnt;
    logic             win_we;
    logic [WIDTH-1:0] win_addr;
    logic [WIDTH-1:0] win_wdata;
    logic             io_hit;
    logic             rd_ok;
    logic [WIDTH-1:0] rd_data;
    stage_t           s1;
    stage_t           s2;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (cpu_req),
        .aux_req (aux_req),
        .gnt     (gnt)
    );

    always_comb begin
        win_we    = gnt[1] ? aux_we    : cpu_we;
        win_addr  = gnt[1] ? aux_addr  : cpu_addr;
        win_wdata = gnt[1] ? aux_wdata : cpu_wdata;
    end

`ifdef IO_KEYS_EN
    logic [2:0] btn_meta;
    logic [2:0] btn_sync;
    key_t       s2_key;

    assign io_hit = (win_addr == IO_ADDR);

    // Buttons idle high, so the synchronizer resets to "not pressed".
    // The code is captured while the access sits in stage 1 and presented with stage 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta <= 3'b111;
            btn_sync <= 3'b111;
            s2_key   <= KEY_NONE;
        end else begin
            btn_meta <= {start_n, left_n, right_n};
            btn_sync <= btn_meta;
            s2_key   <= key_encode(~btn_sync[2], ~btn_sync[1], ~btn_sync[0]);
        end
    end

    assign rd_data = s2.is_io ? WIDTH'(s2_key) : mem_q_b;
`else
    logic unused_keys;

    assign io_hit      = 1'b0;
    assign rd_data     = mem_q_b;
    assign unused_keys = &{1'b0, start_n, left_n, right_n, IO_ADDR, s2.is_io};
`endif

    // Issue stage and response pipeline; address/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_gnt    <= 1'b0;
            aux_gnt    <= 1'b0;
            mem_we_b   <= 1'b0;
            mem_addr_b <= '0;
            mem_data_b <= '0;
            s1         <= '0;
            s2         <= '0;
        end else begin
            cpu_gnt  <= gnt[0];
            aux_gnt  <= gnt[1];
            mem_we_b <= (|gnt) & win_we & ~io_hit;
            if (|gnt) begin
                mem_addr_b <= win_addr;
                mem_data_b <= win_wdata;
            end
            s1 <= '{valid: |gnt, owner: gnt[1] ? OWN_AUX : OWN_CPU, is_read: ~win_we, is_io: io_hit};
            s2 <= s1;
        end
    end

    // RAM data arrives registered, so stage 2 passes it straight through.
    always_comb begin
        rd_ok      = s2.valid & s2.is_read;
        cpu_rvalid = rd_ok & (s2.owner == OWN_CPU);
        aux_rvalid = rd_ok & (s2.owner == OWN_AUX);
        cpu_rdata  = cpu_rvalid ? rd_data : '0;
        aux_rdata  = aux_rvalid ? rd_data : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench for mem_port_arbiter with a RAM model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

`ifdef IO_KEYS_EN
    localparam bit IO_EN = 1'b1;
`else
    localparam bit IO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, aux_req = 0, aux_we = 0;
    logic [15:0] cpu_addr = 0, cpu_wdata = 0, aux_addr = 0, aux_wdata = 0;
    logic        cpu_gnt, cpu_rvalid, aux_gnt, aux_rvalid, mem_we_b;
    logic [15:0] cpu_rdata, aux_rdata, mem_addr_b, mem_data_b, mem_q_b;
    logic        start_n = 1, left_n = 1, right_n = 1;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_we_b(mem_we_b), .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b), .mem_q_b(mem_q_b),
        .start_n(start_n), .left_n(left_n), .right_n(right_n)
    );

    logic [15:0] ram [0:65535];
    logic [15:0] ref_mem [0:65535];

    always @(posedge clk) begin
        if (mem_we_b) ram[mem_addr_b] <= mem_data_b;
        mem_q_b <= ram[mem_addr_b];
    end

    typedef struct {int cyc; bit aux; bit we; logic [15:0] addr; logic [15:0] data;} gnt_e;
    typedef struct {int cyc; bit aux; logic [15:0] data;} rsp_e;
    gnt_e gq[$];
    rsp_e rq[$];

    int cyc = 0;
    bit last_rst = 0;
    bit ref_last_aux = 1;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] key_code();
        return !start_n ? 16'd1 : !left_n ? 16'd2 : !right_n ? 16'd3 : 16'd0;
    endfunction

    // One clock cycle of stimulus; the reference model decides the outcome from the rules.
    task automatic step(input bit rst, input bit cr, input bit cwe, input logic [15:0] ca, input logic [15:0] cd,
                        input bit ar, input bit awe, input logic [15:0] aa, input logic [15:0] ad);
        bit win_aux, we, io;
        logic [15:0] addr, data;
        @(posedge clk);
        #1;
        last_rst = reset;
        cyc++;
        reset = rst;
        cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cd;
        aux_req = ar; aux_we = awe; aux_addr = aa; aux_wdata = ad;
        if (rst) begin
            ref_last_aux = 1;
            while (gq.size() > 0 && gq[$].cyc > cyc) void'(gq.pop_back());
            while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
        end else if (cr || ar) begin
            win_aux = (cr && ar) ? !ref_last_aux : ar;
            ref_last_aux = win_aux;
            we = win_aux ? awe : cwe;
            addr = win_aux ? aa : ca;
            data = win_aux ? ad : cd;
            io = IO_EN && addr == 16'hFFFF;
            gq.push_back('{cyc + 1, win_aux, we && !io, addr, data});
            if (!we) rq.push_back('{cyc + 2, win_aux, io ? key_code() : ref_mem[addr]});
            else if (!io) ref_mem[addr] = data;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: mid-cycle, compare whatever the DUT presents with the queued expectations.
    always @(negedge clk) begin
        gnt_e ge;
        rsp_e re;
        bit eg, er;
        if (cyc > 0) begin
            if (last_rst) begin
                chk("reset_ctrl", 32'({cpu_gnt, aux_gnt, cpu_rvalid, aux_rvalid, mem_we_b}), 32'd0);
                chk("reset_data", {mem_addr_b, mem_data_b}, 32'd0);
                chk("reset_rdata", {cpu_rdata, aux_rdata}, 32'd0);
            end
            eg = gq.size() > 0 && gq[0].cyc == cyc;
            ge = '{0, 0, 0, 16'h0, 16'h0};
            if (eg) ge = gq.pop_front();
            chk("cpu_gnt", 32'(cpu_gnt), 32'(eg && !ge.aux));
            chk("aux_gnt", 32'(aux_gnt), 32'(eg && ge.aux));
            chk("mem_we_b", 32'(mem_we_b), 32'(eg && ge.we));
            if (eg) chk("mem_addr_b", 32'(mem_addr_b), 32'(ge.addr));
            if (eg && ge.we) chk("mem_data_b", 32'(mem_data_b), 32'(ge.data));
            er = rq.size() > 0 && rq[0].cyc == cyc;
            re = '{0, 0, 16'h0};
            if (er) re = rq.pop_front();
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(er && !re.aux));
            chk("aux_rvalid", 32'(aux_rvalid), 32'(er && re.aux));
            chk("cpu_rdata", 32'(cpu_rdata), (er && !re.aux) ? 32'(re.data) : 32'd0);
            chk("aux_rdata", 32'(aux_rdata), (er && re.aux) ? 32'(re.data) : 32'd0);
        end
    end

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return 16'h0010;
            1: return 16'h0200;
            2: return 16'hFFFF;
            default: return 16'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 16'(i) ^ 16'hA5A5;
            ref_mem[i] = 16'(i) ^ 16'hA5A5;
        end
        ram[16'h0010] = 16'hBEEF;
        ref_mem[16'h0010] = 16'hBEEF;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // CPU-only read
        step(0, 1, 0, 16'h0010, 0, 0, 0, 0, 0);
        idle(3);
        // Contention right after reset: CPU, AUX, CPU, AUX
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 16'h0020 + 16'(i), 0, 1, 0, 16'h0040 + 16'(i), 0);
        idle(3);
        // Write then read the same address next cycle
        step(0, 0, 0, 0, 0, 1, 1, 16'h0200, 16'h1234);
        step(0, 1, 0, 16'h0200, 0, 0, 0, 0, 0);
        idle(3);
        // Reset while a read is in flight
        step(0, 1, 0, 16'h0010, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Buttons held, then button register read / write / read back
        left_n = 0;
        right_n = 0;
        idle(3);
        step(0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
        idle(3);
        step(0, 1, 1, 16'hFFFF, 16'h5555, 0, 0, 0, 0);
        step(0, 1, 0, 16'hFFFF, 0, 0, 0, 0, 0);
        idle(3);
        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 6, 1'($urandom), rand_addr(), 16'($urandom),
                 $urandom_range(0, 9) < 6, 1'($urandom), rand_addr(), 16'($urandom));
        idle(4);
        chk("drain", 32'(gq.size() + rq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
